// File: rtl/spi_tx_arbiter_if.sv
// spi_tx_arbiter_if: requester-side and SPI-master-side signals of the transmit arbiter
interface spi_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic [NUM_REQ-1:0]        err;
    logic                      busy;
    logic [DATA_W-1:0]         spi_tx_data;
    logic                      spi_start_tx;
    logic                      spi_tx_done;
    modport slave (
        input  req, req_data, spi_tx_done,
        output ack, err, busy, spi_tx_data, spi_start_tx
    );
    modport master (
        output req, req_data, spi_tx_done,
        input  ack, err, busy, spi_tx_data, spi_start_tx
    );
endinterface

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin sharing of one SPI master transmit channel among requesters
module spi_tx_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic             clk,
    input logic             reset,
    spi_tx_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    typedef enum logic [2:0] {IDLE, START, WAIT, ACK, ERR} state_t;
    state_t              state_q, state_d;
    logic [IW-1:0]       last_q, last_d, g_q, g_d, gnt_idx, cand_idx;
    logic                gnt_found;
    int                  cand;
    logic [TW-1:0]       timer_q, timer_d;
    logic [DATA_W-1:0]   data_q, data_d, gnt_data;
    logic [NUM_REQ-1:0]  ack_q, ack_d, err_q, err_d;
    logic                start_q, start_d, busy_q, busy_d;
    // descending scan so the smallest offset past last_grant is the one kept
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        gnt_data  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand     = int'(last_q) + k + 1;
            cand_idx = IW'(cand >= NUM_REQ ? cand - NUM_REQ : cand);
            if (bus.req[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++)
            if (IW'(i) == gnt_idx) gnt_data = bus.req_data[i*DATA_W +: DATA_W];
    end
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        g_d     = g_q;
        timer_d = timer_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                state_d = gnt_found ? START : IDLE;
                g_d     = gnt_found ? gnt_idx : g_q;
                data_d  = gnt_found ? gnt_data : data_q;
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = &timer_q ? timer_q : timer_q + 1'b1;
                state_d = bus.spi_tx_done ? ACK :
                          (TIMEOUT_CYCLES != 0 && timer_q == TW'(TIMEOUT_CYCLES - 1)) ? ERR : WAIT;
            end
            ACK, ERR: begin
                last_d  = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        start_d = state_d == START;
        busy_d  = state_d != IDLE;
        ack_d   = state_d == ACK ? NUM_REQ'(1) << g_d : '0;
        err_d   = state_d == ERR ? NUM_REQ'(1) << g_d : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            g_q     <= '0;
            timer_q <= '0;
            data_q  <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            g_q     <= g_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.ack          = ack_q;
    assign bus.err          = err_q;
    assign bus.busy         = busy_q;
    assign bus.spi_tx_data  = data_q;
    assign bus.spi_start_tx = start_q;
endmodule
